// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl - scan controller for the VGA output stage.
//
// Runs the horizontal/vertical raster counters and issues linear frame-buffer
// reads one pixel ahead of display. The timing flags (active, hsync, vsync,
// frame start) are delayed by RD_LAT so they reach the VGA output register
// together with the pixel data returned by the frame buffer. Scanning only
// starts in IDLE and only stops at the end of a frame.
//
// Ports:
//   i_p_clk        pixel clock
//   i_rst          asynchronous reset, active-high
//   i_en           scan enable (level)
//   i_fb_ready     frame buffer holds a valid frame (looked at in IDLE only)
//   o_rd_en        frame-buffer read strobe
//   o_rd_addr      linear pixel address of the current read
//   o_hsync        horizontal sync, delayed RD_LAT
//   o_vsync        vertical sync, delayed RD_LAT
//   o_active_area  visible pixel flag, delayed RD_LAT
//   o_frame_start  one-clock pulse with the first visible pixel of a frame
//   o_busy         high while scanning (RUN or STOPPING)
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = 19
) (
    input  logic              i_p_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_fb_ready,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_active_area,
    output logic              o_frame_start,
    output logic              o_busy
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    typedef struct packed {
        logic fs;
        logic vs;
        logic hs;
        logic act;
    } tim_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    // tim_q[0] is the read-strobe stage; tim_q[RD_LAT] is the display stage.
    tim_t              tim_q [0:RD_LAT];
    tim_t              tim_d [0:RD_LAT];

    logic scanning;
    logic frame_end;

    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_POL : ~SYNC_POL;
    endfunction

    always_comb begin
        scanning  = (state_q != ST_IDLE);
        frame_end = (h_q == H_LAST) && (v_q == V_LAST);

        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_en && i_fb_ready) state_d = ST_RUN;
            ST_RUN:      if (!i_en) state_d = ST_STOPPING;
            // Re-enable wins over frame end so a late re-enable keeps scanning.
            ST_STOPPING: begin
                if (i_en) state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);

        // Raster counters
        h_d = '0;
        v_d = '0;
        if (scanning) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end

        // Undelayed timing -> stage 0 (registered act is the read strobe)
        tim_d[0].act = scanning && (h_q < H_ACT_END) && (v_q < V_ACT_END);
        tim_d[0].hs  = scanning && (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        tim_d[0].vs  = scanning && (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        tim_d[0].fs  = tim_d[0].act && (h_q == '0) && (v_q == '0);

        // Stage 0 -> stage RD_LAT: match the frame-buffer read latency
        for (int i = 1; i <= RD_LAT; i++) begin
            tim_d[i] = tim_q[i-1];
        end

        // Address is held at 0 in IDLE so entering RUN always starts at pixel 0.
        // No read is in flight at frame end (last column is blanking).
        addr_d = addr_q;
        if (!scanning || frame_end) begin
            addr_d = '0;
        end else if (tim_q[0].act && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_p_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tim_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            tim_q   <= tim_d;
        end
    end

    assign o_rd_en       = tim_q[0].act;
    assign o_rd_addr     = addr_q;
    assign o_active_area = tim_q[RD_LAT].act;
    assign o_frame_start = tim_q[RD_LAT].fs;
    assign o_hsync       = sync_level(tim_q[RD_LAT].hs);
    assign o_vsync       = sync_level(tim_q[RD_LAT].vs);
    assign o_busy        = busy_q;

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Scan controller for the VGA output stage.
- Generates horizontal/vertical counters, hsync, vsync and the active-area flag.
- Issues linear frame-buffer read requests one pixel ahead of display.
- Delays all timing outputs by the frame-buffer read latency, so pixel data and timing reach the VGA output register stage aligned. Starts, stops and restarts scanning on frame boundaries only.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- RD_LAT, 2, frame-buffer read latency in clocks (1..4)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- ADDR_W, 19, read address width

Ports:
- i_p_clk  in  1  pixel clock
- i_rst  in  1  asynchronous reset, active-high
- i_en  in  1  scan enable (level)
- i_fb_ready  in  1  frame buffer holds a valid frame; sampled only in IDLE
- o_rd_en  out  1  frame-buffer read strobe
- o_rd_addr  out  ADDR_W  linear pixel address
- o_hsync  out  1  horizontal sync, delayed RD_LAT
- o_vsync  out  1  vertical sync, delayed RD_LAT
- o_active_area  out  1  visible pixel flag, delayed RD_LAT
- o_frame_start  out  1  one-clock pulse with first visible pixel of each frame, delayed RD_LAT
- o_busy  out  1  high in RUN or STOPPING

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT (525).
- Counters: h_cnt 0..H_TOT-1, wraps to 0 and increments v_cnt; v_cnt 0..V_TOT-1, wraps to 0. Both run only in RUN/STOPPING.
- Undelayed timing, in RUN/STOPPING:
  - act = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
  - fs = act at h=0,v=0
- Read side, undelayed:
  - o_rd_en = act, registered, so it is asserted one clock after counter state.
  - o_rd_addr holds the address of the current read. It increments by 1 after each read, saturates at H_ACTIVE*V_ACTIVE-1 (no wrap), and is cleared to 0 when v_cnt wraps to 0 or on entering RUN.
- Delay line: act/hs/vs/fs pass through a pipeline so that o_active_area rises exactly RD_LAT clocks after the o_rd_en of pixel 0.
- Sync outputs drive the level SYNC_POL when asserted and ~SYNC_POL otherwise.
- FSM:
  - IDLE: counters held at 0; rd_en=0; syncs inactive. If i_en && i_fb_ready, go to RUN.
  - RUN: scan. If !i_en, go to STOPPING.
  - STOPPING: keep scanning. At the end of the frame (h=H_TOT-1, v=V_TOT-1), go to IDLE. If i_en reasserts before then, return to RUN with no glitch.
- End of frame in RUN: continues straight to the next frame. i_fb_ready is ignored outside IDLE.
- Reset (async, any time):
  - state=IDLE, counters=0, rd_addr=0, delay line flushed.
  - o_rd_en=0, o_active_area=0, o_frame_start=0, o_busy=0.
  - o_hsync=o_vsync=~SYNC_POL.
- Reset mid-frame: all outputs go inactive immediately. Scanning restarts at h=v=0 only after release plus the IDLE start condition.
- Leaving to IDLE: delay-line contents drain to inactive within RD_LAT clocks. No partial sync pulse is truncated, because STOPPING exits only at frame end (vsync/hsync both inactive there).

Test Plan:
- Reset release, i_en=1, i_fb_ready=0 for 100 clocks -> o_busy=0, o_rd_en=0, o_hsync=o_vsync=1. Raise i_fb_ready -> o_busy=1 the next clock; first o_rd_en with addr 0; o_active_area rises RD_LAT=2 clocks after it, coincident with o_frame_start.
- One full frame -> exactly 307200 o_rd_en pulses, addresses 0..307199 contiguous; o_hsync low for 96 clocks starting 656 clocks after line start; o_vsync low on lines 490-491; 420000 clocks per frame.
- Drop i_en at line 100 -> scanning continues to the end of the frame (v=524, h=799), then o_busy=0 and no further reads. Reassert i_en at line 300 instead -> uninterrupted scan, no missing pixels.
- Assert i_rst at h=300, v=200 -> all outputs inactive asynchronously. After release with i_en=i_fb_ready=1, the next read address is 0 and o_frame_start pulses.
- Back-to-back frames -> rd_addr returns to 0 at the frame boundary; o_frame_start exactly one clock per frame; hsync period 800 constant across the v wrap.
- RD_LAT=4, SYNC_POL=1 -> active/sync lag o_rd_en by 4 clocks; syncs idle low, pulse high.
